counter_btn_ctrl: RTL and testbench
===================================

// Module: counter_btn_ctrl
// PURPOSE
//  Command controller for the 0-9999 counter datapath. Debounces three raw push-buttons
//  (run/stop, clear, mode) using one shared sample tick. Arbitrates simultaneous presses
//  and sequences the counter through STOP/RUN/CLEAR, driving its enable, clear and up/down
//  controls. Sits between the board buttons and the counter/FND datapath.
// PARAMETERS
//  TICK_DIV   100_000  clk cycles per debounce sample tick (sim: 10)
//  DB_SAMPLES 4        consecutive high samples needed to declare a press (>=2)
// PORTS
//  clk          input  1  system clock; all logic on posedge clk
//  rst          input  1  synchronous, active-high reset
//  i_btn_run    input  1  raw run/stop button, active-high, asynchronous to clk
//  i_btn_clear  input  1  raw clear button, active-high
//  i_btn_mode   input  1  raw up/down mode button, active-high
//  o_run_en     output 1  counter count enable (1 in RUN)
//  o_clear      output 1  one-cycle counter clear pulse
//  o_up_down    output 1  count direction: 1 = up, 0 = down
//  o_state      output 2  FSM state: 00 STOP, 01 RUN, 10 CLEAR
// BEHAVIOUR
//  Reset: on posedge clk with rst=1: tick counter=0, all sample regs=0, debounced levels=0,
//   edge regs=0, state=STOP, o_run_en=0, o_clear=0, o_up_down=1, o_state=00. rst wins
//   over every other event, including mid-RUN and mid-CLEAR.
//  Tick: counter 0..TICK_DIV-1; tick=1 for one clk when counter==TICK_DIV-1, then wraps to 0.
//   Width $clog2(TICK_DIV). One tick generator shared by all three buttons.
//  Debounce (per button): 2-FF synchroniser on raw input. On tick, shift the synced bit into
//   a DB_SAMPLES-bit register. level = AND of register; any low sample drops level.
//  Event: level_d registered every clk; evt = level & ~level_d, exactly one clk wide.
//   A held button yields one event only; release+repress needed for the next event.
//  Arbitration in the evt cycle, fixed priority clear > run > mode; lower-priority events in
//   the same cycle are discarded, not queued.
//  FSM (registered, evaluated every clk):
//   STOP : clear_evt -> CLEAR; run_evt -> RUN; mode_evt -> toggle o_up_down, stay STOP
//   RUN  : clear_evt -> CLEAR; run_evt -> STOP; mode_evt ignored (no direction change)
//   CLEAR: unconditional -> STOP after one cycle; all events in this cycle discarded
//  Outputs are registered (Moore) and change on the clk edge that enters the new state:
//   o_run_en=1 iff state==RUN; o_clear=1 iff state==CLEAR (exactly 1 clk); o_state=state.
//   o_up_down is unaffected by CLEAR.
//  Latency: raw press stable from clk t -> evt within 2 (sync) + DB_SAMPLES*TICK_DIV + 1 clk;
//   output updates 1 clk after evt.
//  Glitch rejection: pulse shorter than (DB_SAMPLES-1)*TICK_DIV clk never produces evt.
//  Encoding 11 is unreachable; if entered, next state STOP with outputs as STOP.
// TESTING  (TICK_DIV=10, DB_SAMPLES=4)
//  1 Reset: rst=1 for 3 clk, buttons 0 -> o_run_en=0, o_clear=0, o_up_down=1, o_state=00.
//  2 Run press: i_btn_run=1 for 80 clk -> o_run_en 0->1 within 44 clk of press, exactly one
//    transition, o_state=01; second 80-clk press after release -> o_run_en=0, o_state=00.
//  3 Glitch: i_btn_run=1 for 25 clk then 0 -> o_run_en stays 0, no evt ever asserted.
//  4 Simultaneous: STOP, i_btn_clear and i_btn_run rise same clk, held 80 clk -> o_clear=1
//    for exactly 1 clk, o_state 00->10->00, o_run_en stays 0.
//  5 Mode gating: STOP, mode press -> o_up_down 1->0; RUN, mode press -> o_up_down stays 0;
//    clear in RUN -> o_clear pulse, o_state=00, o_up_down still 0.
//  6 Reset mid-op: in RUN with i_btn_run held, rst=1 for 1 clk -> next edge o_state=00,
//    o_run_en=0, o_up_down=1; held button gives no new evt until sample reg refills (40 clk).

Source files
------------

// File: rtl/counter_btn_ctrl_if.sv
// Button-to-counter control bundle: raw push-buttons in, counter controls out.
// master drives the buttons (board/bench side); slave is the controller.
interface counter_btn_ctrl_if;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic       i_btn_mode;
  logic       o_run_en;
  logic       o_clear;
  logic       o_up_down;
  logic [1:0] o_state;

  modport master (
    output i_btn_run, i_btn_clear, i_btn_mode,
    input  o_run_en, o_clear, o_up_down, o_state
  );

  modport slave (
    input  i_btn_run, i_btn_clear, i_btn_mode,
    output o_run_en, o_clear, o_up_down, o_state
  );
endinterface

// File: rtl/counter_btn_ctrl.sv
// Debounces run/clear/mode buttons on a shared tick and sequences the counter STOP/RUN/CLEAR.
// Press-to-output latency: 2 sync + DB_SAMPLES*TICK_DIV + 1 clk to evt, outputs 1 clk later.
module counter_btn_ctrl #(
  parameter int TICK_DIV   = 100_000,
  parameter int DB_SAMPLES = 4
) (
  input logic               clk,
  input logic               rst,
  counter_btn_ctrl_if.slave bus
);

  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  logic [CW-1:0]         tick_cnt;
  logic                  tick;
  logic [2:0]            raw;
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [DB_SAMPLES-1:0] samp [3];
  logic [2:0]            level;
  logic [2:0]            level_d;
  logic [2:0]            evt;
  logic                  clear_evt;
  logic                  run_evt;
  logic                  mode_evt;
  state_t                state;
  state_t                state_nxt;
  logic                  up_down;
  logic                  up_down_nxt;
  logic                  run_en;
  logic                  clear;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Bit order everywhere: [0] run, [1] clear, [2] mode.
  assign raw = {bus.i_btn_mode, bus.i_btn_clear, bus.i_btn_run};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
      for (int i = 0; i < 3; i++) begin
        samp[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          samp[i] <= {samp[i][DB_SAMPLES-2:0], sync2[i]};
        end
      end
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < 3; i++) begin
      level[i] = &samp[i];
    end
  end

  assign evt = level & ~level_d;

  // Fixed priority clear > run > mode; losers are dropped, not held over.
  assign clear_evt = evt[1];
  assign run_evt   = evt[0] & ~evt[1];
  assign mode_evt  = evt[2] & ~evt[1] & ~evt[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_STOP;
      up_down <= 1'b1;
      run_en  <= 1'b0;
      clear   <= 1'b0;
    end else begin
      state   <= state_nxt;
      up_down <= up_down_nxt;
      run_en  <= (state_nxt == ST_RUN);
      clear   <= (state_nxt == ST_CLEAR);
    end
  end

  always_comb begin
    state_nxt   = state;
    up_down_nxt = up_down;
    case (state)
      ST_STOP: begin
        if (clear_evt) begin
          state_nxt = ST_CLEAR;
        end else if (run_evt) begin
          state_nxt = ST_RUN;
        end else if (mode_evt) begin
          up_down_nxt = ~up_down;
        end
      end
      ST_RUN: begin
        if (clear_evt) begin
          state_nxt = ST_CLEAR;
        end else if (run_evt) begin
          state_nxt = ST_STOP;
        end
      end
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  assign bus.o_run_en  = run_en;
  assign bus.o_clear   = clear;
  assign bus.o_up_down = up_down;
  assign bus.o_state   = state;

endmodule

// File: tb/tb_counter_btn_ctrl.sv
// Bench for counter_btn_ctrl: vector table, hand sequences, then random buttons vs a model.
`timescale 1ns/1ps
module tb_counter_btn_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_btn_ctrl_if bus ();

  counter_btn_ctrl #(.TICK_DIV(TD), .DB_SAMPLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [2:0] btn;       // {mode, clear, run}
    int         hold;
    int         exp_state;
    int         exp_ud;
    int         exp_clr;   // clk cycles with o_clear high during the vector
    int         exp_rise;  // o_run_en rising edges during the vector
  } vec_t;
  vec_t vecs [12];

  // Output activity monitor
  int   rises      = 0;
  int   clr_cycles = 0;
  logic prev_run   = 1'b0;
  always @(negedge clk) begin
    if (bus.o_run_en && !prev_run) rises++;
    prev_run = bus.o_run_en;
    if (bus.o_clear) clr_cycles++;
  end

  // Reference model: debounce as a saturating count of consecutive high samples,
  // tick as a modulo cycle count, controller as plain rules on integer state.
  int m_tick = 0;
  bit m_s1 [3];
  bit m_s2 [3];
  int m_hi [3];
  bit m_lvl_d [3];
  int m_st = 0;
  bit m_ud = 1'b1;
  bit mcmp = 1'b0;

  always @(posedge clk) begin
    bit b [3];
    bit lvl [3];
    bit ev [3];
    int nst;
    bit nud;
    b[0] = bus.i_btn_run; b[1] = bus.i_btn_clear; b[2] = bus.i_btn_mode;
    if (rst) begin
      m_tick = 0; m_st = 0; m_ud = 1'b1;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_hi[i] = 0; m_lvl_d[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        lvl[i] = (m_hi[i] >= DB);
        ev[i]  = lvl[i] && !m_lvl_d[i];
      end
      nst = m_st; nud = m_ud;
      if (m_st == 2)                 nst = 0;
      else if (ev[1])                nst = 2;
      else if (ev[0])                nst = (m_st == 1) ? 0 : 1;
      else if (ev[2] && m_st == 0)   nud = !m_ud;
      for (int i = 0; i < 3; i++) begin
        m_lvl_d[i] = lvl[i];
        if (m_tick == TD - 1) m_hi[i] = m_s2[i] ? ((m_hi[i] < DB) ? m_hi[i] + 1 : DB) : 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = b[i];
      end
      m_tick = (m_tick + 1) % TD;
      m_st = nst; m_ud = nud;
    end
  end

  always @(negedge clk) begin
    if (mcmp) begin
      chk("model_state",   int'(bus.o_state),   m_st);
      chk("model_up_down", int'(bus.o_up_down), int'(m_ud));
      chk("model_run_en",  int'(bus.o_run_en),  int'(m_st == 1));
      chk("model_clear",   int'(bus.o_clear),   int'(m_st == 2));
    end
  end

  task automatic set_btn(input logic [2:0] b);
    bus.i_btn_run   = b[0];
    bus.i_btn_clear = b[1];
    bus.i_btn_mode  = b[2];
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    set_btn(b);
    repeat (hold) @(posedge clk);
    #1 set_btn(3'b000);
    repeat (60) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, c0, found, hold;
    vecs[0]  = '{3'b000, 20, 0, 1, 0, 0};
    vecs[1]  = '{3'b100, 80, 0, 0, 0, 0};
    vecs[2]  = '{3'b001, 80, 1, 0, 0, 1};
    vecs[3]  = '{3'b100, 80, 1, 0, 0, 0};
    vecs[4]  = '{3'b010, 80, 0, 0, 1, 0};
    vecs[5]  = '{3'b011, 80, 0, 0, 1, 0};
    vecs[6]  = '{3'b001, 25, 0, 0, 0, 0};
    vecs[7]  = '{3'b101, 80, 1, 0, 0, 1};
    vecs[8]  = '{3'b001, 80, 0, 0, 0, 0};
    vecs[9]  = '{3'b100, 80, 0, 1, 0, 0};
    vecs[10] = '{3'b110, 80, 0, 1, 1, 0};
    vecs[11] = '{3'b111, 80, 0, 1, 1, 0};

    set_btn(3'b000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_run_en",  int'(bus.o_run_en),  0);
    chk("reset_clear",   int'(bus.o_clear),   0);
    chk("reset_up_down", int'(bus.o_up_down), 1);
    chk("reset_state",   int'(bus.o_state),   0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Run press: enable within 44 clk, exactly one transition while held
    r0 = rises;
    bus.i_btn_run = 1'b1;
    found = 0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (bus.o_run_en) begin found = 1; break; end
    end
    chk("run_latency_le44", found, 1);
    repeat (40) @(posedge clk);
    #1 bus.i_btn_run = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("run_state", int'(bus.o_state), 1);
    chk("run_single_rise", rises - r0, 1);
    press(3'b001, 80);
    @(negedge clk);
    chk("stop_state",  int'(bus.o_state),  0);
    chk("stop_run_en", int'(bus.o_run_en), 0);

    foreach (vecs[v]) begin
      r0 = rises; c0 = clr_cycles;
      press(vecs[v].btn, vecs[v].hold);
      @(negedge clk);
      chk($sformatf("vec%0d_state", v),   int'(bus.o_state),   vecs[v].exp_state);
      chk($sformatf("vec%0d_up_down", v), int'(bus.o_up_down), vecs[v].exp_ud);
      chk($sformatf("vec%0d_clear", v),   clr_cycles - c0,     vecs[v].exp_clr);
      chk($sformatf("vec%0d_rises", v),   rises - r0,          vecs[v].exp_rise);
    end

    // Reset mid-RUN with run held: back to STOP/up, re-press only after refill
    press(3'b100, 80);
    @(negedge clk);
    chk("midop_pre_up_down", int'(bus.o_up_down), 0);
    bus.i_btn_run = 1'b1;
    found = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus.o_run_en) begin found = 1; break; end
    end
    chk("midop_enter_run", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_state",   int'(bus.o_state),   0);
    chk("midop_run_en",  int'(bus.o_run_en),  0);
    chk("midop_up_down", int'(bus.o_up_down), 1);
    r0 = rises;
    repeat (30) @(negedge clk);
    chk("midop_no_early_evt", rises - r0, 0);
    found = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.o_run_en) begin found = 1; break; end
    end
    chk("midop_refill_evt", found, 1);
    #1 bus.i_btn_run = 1'b0;

    // Randomized buttons and occasional resets against the model
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mcmp = 1'b1;
    for (int s = 0; s < 80; s++) begin
      set_btn(3'($urandom_range(0, 7)));
      hold = $urandom_range(1, 70);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      repeat (hold) @(posedge clk);
      #1;
    end
    set_btn(3'b000);
    repeat (60) @(posedge clk);
    @(negedge clk);
    mcmp = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
